// File: rtl/fifo_rr_scheduler_pkg.sv
// Shared constants, destination-field layout and FSM encoding for the scheduler.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package fifo_rr_scheduler_pkg;

  localparam int NUM_CH = 4;
  localparam int DEST_W = 2;

  // Destination occupies the two MSBs of a word: word[WORD_SIZE-DEST_MSB_OFS : WORD_SIZE-DEST_LSB_OFS]
  localparam int DEST_MSB_OFS = 1;
  localparam int DEST_LSB_OFS = DEST_W;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

endpackage

// File: rtl/fifo_rr_scheduler_rr_arbiter4.sv
// Combinational 4-way round-robin pick starting at ptr.
// Latency: zero cycles, pure combinational.
// Backpressure: none here; callers mask blocked requesters out of req.
module rr_arbiter4
  import fifo_rr_scheduler_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [1:0]        ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [1:0]        gnt_idx,
  output logic              any_gnt
);

  logic [1:0] idx;

  // Walk ptr, ptr+1, ... (mod 4) and take the first requester found
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    idx     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = ptr + 2'(k);
      if (!any_gnt && req[idx]) begin
        any_gnt      = 1'b1;
        gnt_idx      = idx;
        gnt[idx]     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_rr_scheduler.sv
// Moves one word per cycle from four input FIFOs to four output FIFOs, round-robin, routed by dest MSBs.
// Latency: fifo_rd (combinational) to out_push/out_data/grant_id is exactly one cycle.
// Backpressure: inputs whose head targets an almost-full output are skipped; one word may land after almost_full rises.
module fifo_rr_scheduler
  import fifo_rr_scheduler_pkg::*;
#(
  parameter int WORD_SIZE = 6
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [NUM_CH-1:0]           fifo_empty,
  input  logic [NUM_CH*WORD_SIZE-1:0] fifo_data,
  input  logic [NUM_CH-1:0]           out_almost_full,
  output logic [NUM_CH-1:0]           fifo_rd,
  output logic [NUM_CH-1:0]           out_push,
  output logic [WORD_SIZE-1:0]        out_data,
  output logic [1:0]                  grant_id,
  output logic                        idle
);

  state_t                state_q, state_d;
  logic [1:0]            rr_ptr;
  logic                  run;
  logic [NUM_CH-1:0]     req;
  logic [NUM_CH-1:0]     gnt;
  logic [1:0]            gnt_idx;
  logic                  any_gnt;
  logic [WORD_SIZE-1:0]  head;
  logic [DEST_W-1:0]     head_dest;
  logic [WORD_SIZE-1:0]  gnt_word;
  logic [DEST_W-1:0]     gnt_dest;

  // Grants only while ACTIVE, enabled and out of reset; reset gating keeps fifo_rd low asynchronously
  assign run = (state_q == ACTIVE) && enable && !reset;

  // Eligibility: non-empty input whose head word's destination is not almost full
  always_comb begin
    req       = '0;
    head      = '0;
    head_dest = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      head      = fifo_data[i*WORD_SIZE +: WORD_SIZE];
      head_dest = head[WORD_SIZE-DEST_MSB_OFS : WORD_SIZE-DEST_LSB_OFS];
      req[i]    = run && !fifo_empty[i] && !out_almost_full[head_dest];
    end
  end

  rr_arbiter4 u_arb (
    .req     (req),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any_gnt (any_gnt)
  );

  assign fifo_rd  = gnt;
  assign gnt_word = fifo_data[gnt_idx*WORD_SIZE +: WORD_SIZE];
  assign gnt_dest = gnt_word[WORD_SIZE-DEST_MSB_OFS : WORD_SIZE-DEST_LSB_OFS];

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: enable moves IDLE->ACTIVE, its absence moves ACTIVE->IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable)  state_d = ACTIVE;
      ACTIVE:  if (!enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output registers and round-robin pointer; pointer and word/id only move on a grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr   <= '0;
      out_push <= '0;
      out_data <= '0;
      grant_id <= '0;
    end else if (any_gnt) begin
      rr_ptr   <= gnt_idx + 2'd1;
      out_push <= NUM_CH'(1) << gnt_dest;
      out_data <= gnt_word;
      grant_id <= gnt_idx;
    end else begin
      out_push <= '0;
    end
  end

  // Idle when not scheduling, or when nothing is queued and nothing is landing
  assign idle = (state_q == IDLE) || ((&fifo_empty) && (out_push == '0));

endmodule

// File: doc/fifo_rr_scheduler.md
Name: fifo_rr_scheduler

Overview:
- Moves words from four input FIFOs to four output FIFOs.
- Shares a single datapath word-per-cycle between the input FIFOs using round-robin arbitration.
- Routes each word by the destination field in its two MSBs.
- Drives the input FIFOs' fifo_rd lines and the output FIFOs' push lines; honours output almost-full backpressure.

Parameters:
WORD_SIZE, 6, bits per word; word[WORD_SIZE-1:WORD_SIZE-2] is the destination, range 0..3
NUM_CH, 4, number of input and output channels; fixed at 4, other values unsupported

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
enable  input  1  scheduler run enable
fifo_empty  input  4  empty flag of input FIFO i on bit i
fifo_data  input  4*WORD_SIZE  head word of input FIFO i on bits [i*WORD_SIZE +: WORD_SIZE]; valid combinationally while not empty
out_almost_full  input  4  almost-full flag of output FIFO j on bit j
fifo_rd  output  4  one-hot read strobe to input FIFO i; combinational
out_push  output  4  one-hot push to output FIFO j; registered
out_data  output  WORD_SIZE  word presented with out_push; registered
grant_id  output  2  index of the last granted input; registered
idle  output  1  high in IDLE, or in ACTIVE with all inputs empty and no push in flight

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, out_push=0, out_data=0, grant_id=0, idle=1.
- While reset is high, fifo_rd=0.
- Reset asserted mid-operation: any in-flight word is discarded, with no push.
- FSM states:
  - IDLE: no grants. Go to ACTIVE on the next edge when enable=1.
  - ACTIVE: one grant per cycle. Go to IDLE on the next edge when enable=0. No grant in any cycle where enable=0.
- Eligibility, input i in ACTIVE with enable=1: fifo_empty[i]=0 AND out_almost_full[dest(fifo_data_i)]=0.
- Arbitration:
  - Search order is rr_ptr, rr_ptr+1, ... mod 4. The first eligible input i is granted.
  - Grant raises fifo_rd[i] in the same cycle.
  - On the next edge: out_push[dest]<=1, out_data<=word, grant_id<=i, rr_ptr<=(i+1) mod 4.
  - Latency is exactly one cycle from fifo_rd to out_push.
  - out_push is one-hot or zero and lasts one cycle per word.
- No eligible input: fifo_rd=0, rr_ptr is held, and out_push<=0 on the next edge.
- Blocked inputs are skipped. A blocked destination stalls only the inputs whose head word targets it (no cross-channel head-of-line blocking).
- Back-to-back grants are allowed every cycle, including the same input again when it is the only eligible one.
- Backpressure margin: one word can be in flight after almost_full rises. Output FIFOs must assert almost_full with at least one free entry.
- fifo_rd is never asserted to an empty FIFO, even if enable toggles or fifo_empty changes in the same cycle.
- Simultaneous enable fall and eligible request: no grant that cycle. A push already in flight from the previous cycle still completes.
- Wrap-around: rr_ptr 3 -> 0. Grant of input 3 sets rr_ptr=0.

Decomposition:
- Shared package holds:
  - constants NUM_CH=4 and DEST_W=2
  - destination-field slice positions
  - FSM state encoding IDLE=0, ACTIVE=1
- One sub-module, rr_arbiter4, is natural: combinational 4-way round-robin pick.
  - Inputs: request vector, rr_ptr.
  - Outputs: one-hot grant, grant index, any_grant.
- Top level keeps the FSM, eligibility masking, rr_ptr and output registers.

Test Plan:
1. Reset asserted asynchronously mid-cycle while fifo_rd[2]=1 -> fifo_rd=0 immediately; out_push=0, rr_ptr=0, idle=1; no push of the in-flight word.
2. enable=1, all four inputs non-empty, destinations 0,1,2,3, no almost_full -> grants in order 0,1,2,3,0 on consecutive cycles. out_push one-hot equals 0001,0010,0100,1000 one cycle after each fifo_rd.
3. Inputs 0 and 1 non-empty, both heads with dest=2, out_almost_full=0100 -> fifo_rd stays 0000, idle=0. Clearing almost_full -> grants input 0, then input 1.
4. Input 0 head dest=1 with almost_full[1]=1; input 1 head dest=3 -> input 1 granted every cycle; input 0 never read until almost_full[1] drops.
5. Input 1 head word 6'b10_1011 -> fifo_rd=0010 at cycle t. At t+1: out_push=0100, out_data=6'b101011, grant_id=1, rr_ptr=2.
6. enable dropped in the same cycle input 3 becomes non-empty -> no fifo_rd, state returns to IDLE, idle=1. Re-enable -> input 3 is granted on the first ACTIVE cycle.
